// File: rtl/note_player_pkg.sv
// Shared constants for the song reader and the note player.
//   PHASE_W  : width of the phase accumulator (20 bits)
//   NOTE_W   : width of a note code (0 = rest, 1..63 = pitch index)
//   DUR_W    : width of a note duration in beats
//   SAMPLE_W : width of the signed output sample
//   AMP      : square-wave amplitude
//   state_t  : note player state encoding
package note_player_pkg;

    localparam int unsigned PHASE_W  = 20;
    localparam int unsigned NOTE_W   = 6;
    localparam int unsigned DUR_W    = 6;
    localparam int unsigned SAMPLE_W = 16;

    localparam logic signed [SAMPLE_W-1:0] AMP = 16'sd16383;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/note_player_frequency_rom.sv
// frequency_rom: combinational note-code to phase-step table.
//   addr : note code (0 = rest, 1..63 = pitch index)
//   step : 20-bit phase increment per 48 kHz sample
// Equal-tempered scale: one octave of steps (A4 = note 49 = 440 Hz at
// 48 kHz = 9612) is stored and the other octaves are derived by shifting.
// Code n maps to semitone (n-1)%12 and octave (n-1)/12; octave 4 is the
// stored one.
module frequency_rom
    import note_player_pkg::*;
(
    input  logic [NOTE_W-1:0]  addr,
    output logic [PHASE_W-1:0] step
);

    logic [NOTE_W-1:0]  idx;
    logic [3:0]         semi;
    logic [2:0]         oct;
    logic [PHASE_W-1:0] base;

    always_comb begin
        idx  = addr - 6'd1;
        semi = 4'(idx % 6'd12);
        oct  = 3'(idx / 6'd12);

        case (semi)
            4'd0:    base = 20'd9612;
            4'd1:    base = 20'd10184;
            4'd2:    base = 20'd10789;
            4'd3:    base = 20'd11431;
            4'd4:    base = 20'd12110;
            4'd5:    base = 20'd12830;
            4'd6:    base = 20'd13593;
            4'd7:    base = 20'd14402;
            4'd8:    base = 20'd15258;
            4'd9:    base = 20'd16165;
            4'd10:   base = 20'd17127;
            4'd11:   base = 20'd18145;
            default: base = '0;
        endcase

        step = '0;
        if (addr != '0) begin
            if (oct >= 3'd4) begin
                step = base << (oct - 3'd4);
            end else begin
                step = base >> (3'd4 - oct);
            end
        end
    end

endmodule

// File: rtl/note_player.sv
// note_player: plays one note at a time as a square wave.
//   clk                  : system clock, rising edge
//   reset                : asynchronous active-high reset
//   play                 : 1 = run, 0 = pause (beats ignored, phase frozen, samples 0)
//   note                 : note code, 0 = rest
//   duration             : note length in beats (0 allowed)
//   new_note             : one-cycle strobe loading note/duration
//   beat                 : one-cycle tempo pulse
//   generate_next_sample : one-cycle sample strobe
//   sample_out           : signed sample, valid with new_sample_ready
//   new_sample_ready     : pulses one cycle after each sample strobe
//   note_done            : one-cycle pulse when the current note finishes
module note_player
    import note_player_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play,
    input  logic [NOTE_W-1:0]          note,
    input  logic [DUR_W-1:0]           duration,
    input  logic                       new_note,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       new_sample_ready,
    output logic                       note_done
);

    state_t             state;
    logic [NOTE_W-1:0]  cur_note;
    logic [DUR_W-1:0]   remaining;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] step;
    logic [PHASE_W-1:0] phase_adv;
    logic               advance;

    frequency_rom u_rom (
        .addr (cur_note),
        .step (step)
    );

    always_comb begin
        advance   = (state == ST_PLAYING) && play && generate_next_sample;
        phase_adv = phase + step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            cur_note         <= '0;
            remaining        <= '0;
            phase            <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            note_done        <= 1'b0;
        end else begin
            new_sample_ready <= generate_next_sample;
            note_done        <= 1'b0;

            // The sample reflects the note sounding in this cycle; a load in
            // the same cycle only affects subsequent samples.
            if (generate_next_sample) begin
                if (advance && cur_note != '0) begin
                    sample_out <= phase_adv[PHASE_W-1] ? -AMP : AMP;
                end else begin
                    sample_out <= '0;
                end
            end
            if (advance) begin
                phase <= phase_adv;
            end

            // note_done is raised on entry to DONE so it coincides with it.
            if (new_note) begin
                cur_note  <= note;
                remaining <= duration;
                phase     <= '0;
                if (duration == '0) begin
                    state     <= ST_DONE;
                    note_done <= 1'b1;
                end else begin
                    state <= ST_PLAYING;
                end
            end else begin
                case (state)
                    ST_PLAYING: begin
                        if (beat && play) begin
                            remaining <= remaining - 6'd1;
                            if (remaining == 6'd1) begin
                                state     <= ST_DONE;
                                note_done <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player. The driver predicts each response from a
// beat-counting / phase-arithmetic model and queues it tagged with the clock
// edge it belongs to; the monitor compares what the DUT presents each cycle.
// Only rests and A notes (13, 25, 37, 49, 61) are played, whose steps are
// 9612 (A4 at 48 kHz) halved or doubled per octave.
module tb_note_player;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               play = 1'b0;
    logic [5:0]         note = '0;
    logic [5:0]         duration = '0;
    logic               new_note = 1'b0;
    logic               beat = 1'b0;
    logic               gns = 1'b0;
    logic signed [15:0] sample_out;
    logic               new_sample_ready;
    logic               note_done;

    always #5 clk = ~clk;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .note                 (note),
        .duration             (duration),
        .new_note             (new_note),
        .beat                 (beat),
        .generate_next_sample (gns),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .note_done            (note_done)
    );

    typedef struct {
        int                 edge_idx;
        logic signed [15:0] val;
    } samp_t;

    samp_t samp_q[$];
    int    done_q[$];

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    // Reference model: is a note sounding, beats left, note code, phase.
    bit          m_sounding = 1'b0;
    int          m_left     = 0;
    int          m_note     = 0;
    int unsigned m_phase    = 0;

    int a_notes[6] = '{0, 13, 25, 37, 49, 61};

    function automatic int unsigned note_step(int n);
        int oct;
        if (n == 0) return 0;
        oct = (n - 1) / 12;
        return (32'd9612 << oct) >> 4;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // Predict the outcome of clock edge k from the inputs now applied.
    function automatic void model(int k);
        int v;
        if (gns) begin
            v = 0;
            if (m_sounding && play) begin
                m_phase = (m_phase + note_step(m_note)) % 32'd1048576;
                if (m_note != 0) v = (m_phase >= 32'd524288) ? -16383 : 16383;
            end
            samp_q.push_back('{k, 16'(v)});
        end
        if (new_note) begin
            m_note  = int'(note);
            m_left  = int'(duration);
            m_phase = 0;
            m_sounding = (m_left != 0);
            if (m_left == 0) done_q.push_back(k);
        end else if (m_sounding && beat && play) begin
            m_left--;
            if (m_left == 0) begin
                m_sounding = 1'b0;
                done_q.push_back(k);
            end
        end
    endfunction

    task automatic drive(bit p, bit nn, int n, int d, bit b, bit g);
        @(negedge clk);
        play     = p;
        new_note = nn;
        note     = 6'(n);
        duration = 6'(d);
        beat     = b;
        gns      = g;
        model(edge_cnt + 1);
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(int hold);
        @(negedge clk);
        reset    = 1'b1;
        play     = 1'b0;
        new_note = 1'b0;
        beat     = 1'b0;
        gns      = 1'b0;
        #1;
        check("reset_sample_out", int'(sample_out), 0);
        check("reset_ready", int'(new_sample_ready), 0);
        check("reset_note_done", int'(note_done), 0);
        samp_q.delete();
        done_q.delete();
        m_sounding = 1'b0;
        m_left     = 0;
        m_note     = 0;
        m_phase    = 0;
        repeat (hold) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor
    samp_t s;
    bit    exp_rdy;
    bit    exp_done;

    always @(posedge clk) begin
        #1;
        edge_cnt++;
        exp_rdy = (samp_q.size() > 0) && (samp_q[0].edge_idx == edge_cnt);
        check("new_sample_ready", int'(new_sample_ready), int'(exp_rdy));
        if (exp_rdy) begin
            s = samp_q.pop_front();
            check("sample_out", int'(sample_out), int'(s.val));
        end
        exp_done = (done_q.size() > 0) && (done_q[0] == edge_cnt);
        check("note_done", int'(note_done), int'(exp_done));
        if (exp_done) void'(done_q.pop_front());
    end

    initial begin
        // Reset values
        do_reset(3);

        // 3-beat note: done one cycle after the third beat
        drive(1, 1, 49, 3, 0, 0);
        idle(2);
        drive(1, 0, 0, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 1, 0);
        idle(3);
        drive(1, 0, 0, 0, 1, 0);
        idle(3);

        // Zero duration, then strobes and beats while not playing
        drive(1, 1, 49, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1, 1);
        idle(2);

        // Phase accumulation over 60 strobes (first sign flip at strobe 55)
        drive(1, 1, 49, 63, 0, 0);
        for (int i = 0; i < 60; i++) drive(1, 0, 0, 0, 0, 1);
        idle(2);

        // Pause mid-note: 10 ignored beats, samples forced to 0
        drive(1, 1, 49, 2, 0, 0);
        drive(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 1);
        idle(3);

        // new_note in the DONE cycle, then new_note colliding with a beat
        drive(1, 1, 49, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        drive(1, 1, 25, 2, 0, 1);
        drive(1, 0, 0, 0, 1, 1);
        drive(1, 1, 37, 1, 1, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 1);
        idle(3);

        // Reset mid-note abandons it without note_done
        drive(1, 1, 49, 5, 0, 0);
        drive(1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 1);
        do_reset(2);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 1, 1);
        drive(1, 1, 61, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 1);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end else begin
                drive($urandom_range(0, 7) != 0,
                      $urandom_range(0, 19) == 0,
                      a_notes[$urandom_range(0, 5)],
                      int'($urandom_range(0, 4)),
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 2) == 0);
            end
        end
        idle(4);
        @(posedge clk);
        #2;
        check("queues_drained", samp_q.size() + done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
